// File: rtl/tx_frame_sequencer_if.sv
// Bit-path bundle between the frame sequencer, the PSDU serializer and the scrambler.
// A bit transfers on a cycle where BitValid && BitReady; BitValid never depends on BitReady.
interface tx_frame_sequencer_if #(
    parameter int LEN_WIDTH = 12
);
    logic                 Start;
    logic [LEN_WIDTH-1:0] Length;
    logic [7:0]           Ndbps;
    logic [6:0]           Seed;
    logic                 DataIn;
    logic                 BitReady;
    logic                 DataReq;
    logic                 BitOut;
    logic                 BitValid;
    logic                 ScrLoad;
    logic [6:0]           ScrSeed;
    logic                 TailZero;
    logic                 Busy;
    logic                 Done;

    modport master (
        input  Start, Length, Ndbps, Seed, DataIn, BitReady,
        output DataReq, BitOut, BitValid, ScrLoad, ScrSeed, TailZero, Busy, Done
    );

    modport slave (
        output Start, Length, Ndbps, Seed, DataIn, BitReady,
        input  DataReq, BitOut, BitValid, ScrLoad, ScrSeed, TailZero, Busy, Done
    );
endinterface

// File: rtl/tx_frame_sequencer.sv
// 802.11a transmit frame sequencer: SERVICE, PSDU, tail and pad bits toward the scrambler.
// StateDbg exposes the FSM state register.
module tx_frame_sequencer #(
    parameter int LEN_WIDTH = 12
) (
    input  logic                  Clock,
    input  logic                  Reset,
    tx_frame_sequencer_if.master  bus,
    output logic [2:0]            StateDbg
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SERVICE = 3'd2,
        S_DATA    = 3'd3,
        S_TAIL    = 3'd4,
        S_PAD     = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    localparam int SW = LEN_WIDTH + 3;

    state_e               state_q, state_d;
    logic [SW-1:0]        sec_q, sec_d, data_last;
    logic [7:0]           sym_q, sym_d, sym_inc;
    logic [LEN_WIDTH-1:0] len_q;
    logic [7:0]           ndbps_q;
    logic [6:0]           seed_q;
    logic                 busy_q, valid_q, load_q, tail_q, done_q, data_q;
    logic                 xfer, start_ok;

    assign xfer      = valid_q & bus.BitReady;
    assign start_ok  = bus.Start && (bus.Ndbps >= 8'd24);
    assign sym_inc   = (sym_q == ndbps_q - 8'd1) ? 8'd0 : sym_q + 8'd1;
    assign data_last = {len_q, 3'b000} - SW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_LOAD;
            S_LOAD:    state_d = S_SERVICE;
            S_SERVICE: if (xfer && sec_q == SW'(15)) state_d = (len_q == '0) ? S_TAIL : S_DATA;
            S_DATA:    if (xfer && sec_q == data_last) state_d = S_TAIL;
            // Pad only if the tail did not land exactly on a symbol boundary.
            S_TAIL:    if (xfer && sec_q == SW'(5)) state_d = (sym_inc == 8'd0) ? S_DONE : S_PAD;
            S_PAD:     if (xfer && sym_inc == 8'd0) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        sym_d = sym_q;
        if (state_q == S_LOAD) sym_d = 8'd0;
        else if (xfer)         sym_d = sym_inc;

        sec_d = sec_q;
        if (state_d != state_q) sec_d = '0;
        else if (xfer)          sec_d = sec_q + SW'(1);
    end

    // Output flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            sym_q   <= '0;
            len_q   <= '0;
            ndbps_q <= '0;
            seed_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
            tail_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            sym_q   <= sym_d;
            if (state_q == S_IDLE && start_ok) begin
                len_q   <= bus.Length;
                ndbps_q <= bus.Ndbps;
                seed_q  <= (bus.Seed == 7'd0) ? 7'h7F : bus.Seed;
            end
            busy_q  <= (state_d != S_IDLE);
            valid_q <= (state_d == S_SERVICE) || (state_d == S_DATA) ||
                       (state_d == S_TAIL)    || (state_d == S_PAD);
            load_q  <= (state_d == S_LOAD);
            tail_q  <= (state_d == S_TAIL);
            done_q  <= (state_d == S_DONE);
            data_q  <= (state_d == S_DATA);
        end
    end

    assign bus.BitOut   = data_q & bus.DataIn;
    assign bus.DataReq  = data_q & bus.BitReady;
    assign bus.BitValid = valid_q;
    assign bus.ScrLoad  = load_q;
    assign bus.ScrSeed  = seed_q;
    assign bus.TailZero = tail_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign StateDbg     = state_q;
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: scoreboarded bit stream, stalls, boundaries and reset abort.
module tb_tx_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_frame_sequencer_if #(.LEN_WIDTH(12)) bus();
    logic [2:0] state_dbg;

    tx_frame_sequencer #(.LEN_WIDTH(12)) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .bus      (bus),
        .StateDbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];   // {TailZero, BitOut}
    logic       data_bits[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {20'd0, bus.Busy, bus.Done, bus.ScrLoad, bus.BitValid, bus.DataReq,
                bus.TailZero, bus.BitOut, bus.ScrSeed[4:0]} | {25'd0, bus.ScrSeed[6:5], 5'd0} << 0;
    endfunction

    task automatic check_reset_outs(input string tag);
        check_val(tag, {bus.Busy, bus.Done, bus.ScrLoad, bus.BitValid, bus.DataReq,
                        bus.TailZero, bus.BitOut, bus.ScrSeed}, 32'd0);
    endtask

    // Drives one frame and scores it; abort_at >= 0 resets the DUT after that many transfers.
    task automatic run_frame(input int len, input int ndbps, input logic [6:0] seed,
                             input int stall_pct, input int start_at, input int abort_at);
        int pad, total, nxfer, nreq, ndone, load_cyc, done_cyc, didx, cyc;
        logic [6:0] exp_seed;
        logic [1:0] e;
        logic stalled, bo_prev, finished;
        logic [2:0] st_prev;
        data_bits.delete();
        exp_q.delete();
        for (int i = 0; i < 8 * len; i++) data_bits.push_back(1'($urandom_range(0, 1)));
        pad   = (ndbps - (22 + 8 * len) % ndbps) % ndbps;
        total = 22 + 8 * len + pad;
        for (int i = 0; i < 16; i++)      exp_q.push_back(2'b00);
        for (int i = 0; i < 8 * len; i++) exp_q.push_back({1'b0, data_bits[i]});
        for (int i = 0; i < 6; i++)       exp_q.push_back(2'b10);
        for (int i = 0; i < pad; i++)     exp_q.push_back(2'b00);
        exp_seed = (seed == 7'd0) ? 7'h7F : seed;
        nxfer = 0; nreq = 0; ndone = 0; load_cyc = -1; done_cyc = -1; didx = 0;
        stalled = 1'b0; bo_prev = 1'b0; st_prev = 3'd0; finished = 1'b0;

        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Length = 12'(len);
        bus.Ndbps  = 8'(ndbps);
        bus.Seed   = seed;
        bus.BitReady = 1'b1;
        for (cyc = 1; cyc < 4000; cyc++) begin
            @(negedge clk);
            bus.Start    = (cyc == start_at);
            bus.Length   = 12'($urandom_range(0, 4095));
            bus.Ndbps    = 8'($urandom_range(0, 255));
            bus.Seed     = 7'($urandom_range(0, 127));
            bus.BitReady = ($urandom_range(0, 99) >= stall_pct);
            bus.DataIn   = (didx < data_bits.size()) ? data_bits[didx] : 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                check_val("hold_state", 32'(state_dbg), 32'(st_prev));
                check_val("hold_bit", 32'(bus.BitOut), 32'(bo_prev));
            end
            if (ndone > 0) begin
                check_val("busy_fall", 32'(bus.Busy), 32'd0);
                finished = 1'b1;
                break;
            end
            if (bus.ScrLoad) begin
                load_cyc = cyc;
                check_val("scr_seed", 32'(bus.ScrSeed), 32'(exp_seed));
            end
            if (bus.Done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (bus.BitValid && bus.BitReady) begin
                nxfer++;
                if (exp_q.size() == 0) check_val("extra_bit", 32'(nxfer), 32'(total));
                else begin
                    e = exp_q.pop_front();
                    check_val("bit", 32'({bus.TailZero, bus.BitOut}), 32'(e));
                end
            end
            if (bus.DataReq) begin
                nreq++;
                didx++;
            end
            stalled = bus.BitValid && !bus.BitReady;
            st_prev = state_dbg;
            bo_prev = bus.BitOut;
            if (abort_at >= 0 && nxfer == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outs("abort_outs");
                check_val("abort_state", 32'(state_dbg), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check_val("abort_no_done", 32'(bus.Done), 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
        end
        if (!finished) check_val("timeout", 32'(cyc), 32'd0);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("xfer_count", 32'(nxfer), 32'(total));
        check_val("datareq_count", 32'(nreq), 32'(8 * len));
        check_val("done_count", 32'(ndone), 32'd1);
        check_val("load_cycle", 32'(load_cyc), 32'd1);
        if (stall_pct == 0) check_val("done_latency", 32'(done_cyc - load_cyc), 32'(total + 1));
    endtask

    initial begin
        bus.Start = 1'b0; bus.Length = '0; bus.Ndbps = '0; bus.Seed = '0;
        bus.DataIn = 1'b0; bus.BitReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outs("reset_outs");
        check_val("reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(1, 24, 7'h5D, 0, -1, -1);
        run_frame(0, 24, 7'h11, 0, -1, -1);
        run_frame(3, 48, 7'h2A, 0, -1, -1);
        run_frame(100, 216, 7'h33, 0, -1, -1);
        run_frame(5, 36, 7'h45, 50, -1, -1);
        run_frame(2, 24, 7'h00, 0, -1, -1);
        run_frame(3, 48, 7'h12, 0, 21, -1);
        run_frame(4, 72, 7'h19, 0, -1, -1);

        // Too-small Ndbps is rejected in IDLE.
        @(negedge clk);
        bus.Start = 1'b1; bus.Ndbps = 8'd12; bus.Length = 12'd4; bus.Seed = 7'h22;
        @(negedge clk);
        bus.Start = 1'b0;
        #1;
        check_val("ndbps12_busy", 32'(bus.Busy), 32'd0);
        check_val("ndbps12_state", 32'(state_dbg), 32'd0);
        check_val("ndbps12_load", 32'(bus.ScrLoad), 32'd0);

        run_frame(5, 24, 7'h3C, 0, -1, 20);
        repeat (2) @(negedge clk);
        run_frame(2, 96, 7'h07, 25, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
